// File: rtl/debug_uart_tx_if.sv
// Debug UART transmitter bundle: frame request and CPU debug bytes in, serial line and status out.
interface debug_uart_tx_if;
    logic       start;
    logic [7:0] debug_port1;
    logic [7:0] debug_port2;
    logic [7:0] debug_port3;
    logic [7:0] debug_port4;
    logic [7:0] debug_port5;
    logic [7:0] debug_port6;
    logic [7:0] debug_port7;
    logic       tx;
    logic       busy;
    logic       done;

    modport master (
        output start, debug_port1, debug_port2, debug_port3, debug_port4,
               debug_port5, debug_port6, debug_port7,
        input  tx, busy, done
    );

    modport slave (
        input  start, debug_port1, debug_port2, debug_port3, debug_port4,
               debug_port5, debug_port6, debug_port7,
        output tx, busy, done
    );
endinterface

// File: rtl/debug_uart_tx.sv
// 8N1 frame sender: SYNC_BYTE + 7 snapshotted debug bytes (+ XOR checksum when DEBUG_TX_CHECKSUM_EN is defined).
// tx falls the cycle after start is taken; no backpressure, start is ignored while busy and on the done edge.
module debug_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic          clk,
    input  logic          rst,
    debug_uart_tx_if.slave bus
);

    localparam int unsigned      CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
`ifdef DEBUG_TX_CHECKSUM_EN
    localparam int unsigned      NUM_BYTES = 9;
`else
    localparam int unsigned      NUM_BYTES = 8;
`endif
    localparam logic [3:0]       LAST_BYTE = 4'(NUM_BYTES - 1);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] START_BIT = 2'd1;
    localparam logic [1:0] DATA_BITS = 2'd2;
    localparam logic [1:0] STOP_BIT  = 2'd3;

    logic [1:0]       state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [3:0]       byte_idx;
    logic [7:0]       snap [1:7];
    logic [7:0]       cur_byte;
    logic [2:0]       bit_next;
    logic             tx_q;
    logic             busy_q;
    logic             done_q;

    assign bus.tx   = tx_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bit_next = bit_idx + 3'd1;

    always_comb begin
        cur_byte = SYNC_BYTE;
        case (byte_idx)
            4'd1:    cur_byte = snap[1];
            4'd2:    cur_byte = snap[2];
            4'd3:    cur_byte = snap[3];
            4'd4:    cur_byte = snap[4];
            4'd5:    cur_byte = snap[5];
            4'd6:    cur_byte = snap[6];
            4'd7:    cur_byte = snap[7];
`ifdef DEBUG_TX_CHECKSUM_EN
            4'd8:    cur_byte = snap[1] ^ snap[2] ^ snap[3] ^ snap[4]
                              ^ snap[5] ^ snap[6] ^ snap[7];
`endif
            default: cur_byte = SYNC_BYTE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            for (int i = 1; i <= 7; i++) snap[i] <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        snap[1]  <= bus.debug_port1;
                        snap[2]  <= bus.debug_port2;
                        snap[3]  <= bus.debug_port3;
                        snap[4]  <= bus.debug_port4;
                        snap[5]  <= bus.debug_port5;
                        snap[6]  <= bus.debug_port6;
                        snap[7]  <= bus.debug_port7;
                        state    <= START_BIT;
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        byte_idx <= '0;
                        tx_q     <= 1'b0;
                        busy_q   <= 1'b1;
                    end
                end
                START_BIT: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= DATA_BITS;
                        tx_q     <= cur_byte[0];
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA_BITS: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        bit_idx  <= bit_next;
                        if (bit_idx == 3'd7) begin
                            state <= STOP_BIT;
                            tx_q  <= 1'b1;
                        end else begin
                            tx_q  <= cur_byte[bit_next];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        // Last stop bit: leave on the same edge that raises done.
                        if (byte_idx == LAST_BYTE) begin
                            state    <= IDLE;
                            byte_idx <= '0;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            tx_q     <= 1'b1;
                        end else begin
                            byte_idx <= byte_idx + 4'd1;
                            state    <= START_BIT;
                            tx_q     <= 1'b0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debug_uart_tx.sv
// Directed-plus-random bench for debug_uart_tx at CLKS_PER_BIT=4 against a per-cycle line-level model.
module tb_debug_uart_tx;

    localparam int CPB = 4;
`ifdef DEBUG_TX_CHECKSUM_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif
    localparam int FRAME_CYC = NB * 10 * CPB;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    debug_uart_tx_if bus ();

    debug_uart_tx #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ports(input logic [55:0] p);
        bus.debug_port1 = p[7:0];
        bus.debug_port2 = p[15:8];
        bus.debug_port3 = p[23:16];
        bus.debug_port4 = p[31:24];
        bus.debug_port5 = p[39:32];
        bus.debug_port6 = p[47:40];
        bus.debug_port7 = p[55:48];
    endtask

    // Reference: byte i of the frame for a given port snapshot.
    function automatic logic [7:0] frame_byte(input int i, input logic [55:0] p);
        logic [7:0] x;
        if (i == 0) return 8'hA5;
        if (i <= 7) return p[8*(i-1) +: 8];
        x = 8'h00;
        for (int j = 0; j < 7; j++) x = x ^ p[8*j +: 8];
        return x;
    endfunction

    // Reference: line level k cycles after the first falling edge of tx.
    function automatic logic exp_tx(input int k, input logic [55:0] p);
        int         bpos;
        logic [7:0] b;
        b    = frame_byte(k / (10 * CPB), p);
        bpos = (k % (10 * CPB)) / CPB;
        if (bpos == 0) return 1'b0;
        if (bpos == 9) return 1'b1;
        return b[bpos-1];
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_check(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            check({tag, "_tx"}, 32'(bus.tx), 32'd1);
            check({tag, "_busy"}, 32'(bus.busy), 32'd0);
            check({tag, "_done"}, 32'(bus.done), 32'd0);
            step();
        end
    endtask

    // mode 0: one-cycle start; mode 1: start held high; mode 2: pulse, then start only on the done edge.
    task automatic run_frame(input string tag, input logic [55:0] p, input int mode, input bit scramble);
        set_ports(p);
        bus.start = 1'b1;
        step();
        if (mode != 1) bus.start = 1'b0;
        for (int k = 0; k < FRAME_CYC; k++) begin
            check({tag, "_tx"}, 32'(bus.tx), 32'(exp_tx(k, p)));
            check({tag, "_busy"}, 32'(bus.busy), 32'd1);
            check({tag, "_done"}, 32'(bus.done), 32'd0);
            if (scramble && k == 45) set_ports({56{1'b1}});
            if (mode == 2 && k == FRAME_CYC - 1) bus.start = 1'b1;
            step();
        end
        check({tag, "_done_pulse"}, 32'(bus.done), 32'd1);
        check({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
        check({tag, "_tx_end"}, 32'(bus.tx), 32'd1);
        if (mode == 2) bus.start = 1'b0;
    endtask

    initial begin
        logic [55:0] p;
        rst       = 1'b1;
        bus.start = 1'b0;
        set_ports(56'h0);
        #1;
        check("reset_tx", 32'(bus.tx), 32'd1);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        step(); step();
        rst = 1'b0;
        step();

        idle_check("idle", 100);

        run_frame("full", 56'h40_20_10_08_04_02_01, 0, 1'b0);
        step();
        check("full_done_one_cycle", 32'(bus.done), 32'd0);
        idle_check("after_full", 5);

        // Ports scrambled mid-frame with start held: snapshot must hold, and the next frame follows immediately.
        p = 56'h77_66_55_44_33_22_11;
        run_frame("snap", p, 1, 1'b1);
        step();
        check("snap_restart_tx", 32'(bus.tx), 32'd0);
        check("snap_restart_busy", 32'(bus.busy), 32'd1);
        bus.start = 1'b0;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        step();
        idle_check("snap_cleared", 3);

        // Abort during data bit 3 of byte 2.
        p[31:0]  = $urandom();
        p[55:32] = 24'($urandom());
        set_ports(p);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int k = 0; k < 2 * 10 * CPB + 4 * CPB + 1; k++) begin
            check("pre_abort_tx", 32'(bus.tx), 32'(exp_tx(k, p)));
            step();
        end
        rst = 1'b1;
        #1;
        check("abort_tx", 32'(bus.tx), 32'd1);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        bus.start = 1'b1;
        step(); step();
        check("start_in_reset_busy", 32'(bus.busy), 32'd0);
        bus.start = 1'b0;
        rst = 1'b0;
        idle_check("post_abort", 60);

        for (int f = 0; f < 3; f++) begin
            p[31:0]  = $urandom();
            p[55:32] = 24'($urandom());
            run_frame("rand", p, 0, 1'b0);
            step();
        end

        p[31:0]  = $urandom();
        p[55:32] = 24'($urandom());
        run_frame("done_edge", p, 2, 1'b0);
        step();
        idle_check("start_at_done", 20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/debug_uart_tx.md
DEBUG_UART_TX -- requirements
Module: debug_uart_tx

Interface
REQ-001 CLKS_PER_BIT, default 434, clock cycles per UART bit (50 MHz / 115200); legal range 2..65535.
REQ-002 SYNC_BYTE, default 8'hA5, first byte of every frame.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  frame request; sampled on each rising edge.
REQ-006 debug_port1..debug_port7  input  8 each  CPU debug bytes (instruction code, Rn data, Rd data, cycle counter, rm, rn, rd).
REQ-007 tx  output  1  serial line, 8N1, idle high.
REQ-008 busy  output  1  frame in progress.
REQ-009 done  output  1  one-cycle pulse at frame end.

Function
REQ-010 The FSM SHALL have four states: IDLE, START_BIT, DATA_BITS, STOP_BIT.
REQ-011 In IDLE, tx=1, busy=0, and done=0 except for the single done cycle.
REQ-012 A start=1 sampled in IDLE SHALL snapshot debug_port1..7 into internal registers, set busy=1, and enter START_BIT; tx SHALL go low in the cycle after the sampling edge.
REQ-013 start SHALL be ignored while busy=1; the snapshot SHALL NOT change mid-frame, even if the ports change.
REQ-014 Frame byte order: SYNC_BYTE, then port1 through port7, then the checksum byte (REQ-026).
REQ-015 Each byte: one start bit (0), 8 data bits LSB first, one stop bit (1); each bit held exactly CLKS_PER_BIT cycles.
REQ-016 There SHALL be no idle gap between bytes; the stop bit of byte n is followed directly by the start bit of byte n+1.
REQ-017 Transitions:
- START_BIT->DATA_BITS after CLKS_PER_BIT cycles.
- DATA_BITS->STOP_BIT after 8 bits.
- STOP_BIT->START_BIT if bytes remain, else ->IDLE.
REQ-018 The baud counter SHALL count 0..CLKS_PER_BIT-1 and wrap to 0 at each bit boundary; its width is $clog2(CLKS_PER_BIT).
REQ-019 The bit index SHALL be 3 bits and wrap 7->0 at the DATA_BITS exit; the byte index SHALL be 4 bits.
REQ-020 On the edge ending the final stop bit, done SHALL pulse high for one cycle and busy SHALL fall on that same edge.
REQ-021 A start=1 sampled on the done edge SHALL be ignored; start is accepted from the next edge onward.
REQ-022 Total frame length SHALL be (bytes x 10 x CLKS_PER_BIT) cycles from the first tx low to busy low.

Reset
REQ-023 rst=1 SHALL immediately force tx=1, busy=0, done=0, state=IDLE, and clear all counters and snapshot registers to 0, without waiting for a clock edge.
REQ-024 A reset asserted mid-frame SHALL abort the frame; no done pulse is emitted, and after deassertion the block SHALL wait for a new start.
REQ-025 start SHALL be ignored while rst=1.

Configuration
REQ-026 Macro DEBUG_TX_CHECKSUM_EN:
- Defined: a 9th byte equal to the XOR of the port1..port7 snapshot is sent; frame = 9 bytes.
- Undefined: no checksum byte; frame = 8 bytes; no checksum logic is synthesised.

Verification (CLKS_PER_BIT=4)
REQ-027 Idle: after reset, with start=0 for 100 cycles -> tx=1, busy=0, done=0 throughout.
REQ-028 Full frame: ports=01,02,04,08,10,20,40, one-cycle start pulse -> tx carries bytes A5,01,02,04,08,10,20,40,7F LSB-first with correct framing; done pulses exactly 360 cycles after the first tx low (320 cycles with 8 bytes, macro undefined).
REQ-029 Snapshot: change all ports to FF during the frame and hold start=1 continuously -> transmitted bytes are unchanged; exactly one frame is sent before done; a new frame starts 1 cycle after the done cycle.
REQ-030 Reset mid-frame: assert rst during bit 3 of byte 2 -> tx=1 and busy=0 in the same cycle, no done pulse; a later start sends a complete fresh frame.
REQ-031 Bit timing: check every tx transition lands on a multiple of 4 cycles from the first falling edge; the 10th bit of every byte is 1.
REQ-032 Start at done: start=1 only on the done edge -> no frame is started and busy stays 0.
